// File: rtl/sram_resp.sv
// sram_resp: 32-bit load/store responder for a 16-bit asynchronous SRAM, two half-word phases per word.
//   Optional feature: SRAM_WR_SKIP_EN skips store phases whose two byte enables are both clear.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     req_vld/req_rdy                   request handshake
//     req_addr, req_wr                  byte address (bits [1:0] ignored), 1 = store
//     req_wdata, req_bmask              store data and byte enables
//     rsp_vld, rsp_rdata                one-cycle completion pulse, load data (held)
//     sram_addr, sram_dq_o/_i/_oe       half-word address, data out/in, pad output enable
//     sram_ce_n/oe_n/we_n/lb_n/ub_n     active-low SRAM strobes
module sram_resp #(
   parameter int ADDR_W   = 18,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic [ADDR_W:0]   req_addr,
   input  logic              req_wr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_bmask,
   output logic              rsp_vld,
   output logic [31:0]       rsp_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_o,
   input  logic [15:0]       sram_dq_i,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);
   localparam int CW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ADDR_W-2:0] idx_q, idx;
   logic wr_q, wr;
   logic [3:0] bm_q, bm;
   logic [31:0] wd_q, wd;
   logic [15:0] lo_q, lo_d;
   logic [31:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0] dq_q, dq_d;
   logic ce_q, ce_d, oe_q, oe_d, we_q, we_d, lb_q, lb_d, ub_q, ub_d, dqoe_q, dqoe_d, vld_q, vld_d;
   logic acc, last, skip_lo, skip_hi, ph, ph_hi;
   logic unused_addr;
   assign unused_addr = ^req_addr[1:0];
   assign acc = state_q == IDLE && req_vld;
   // request fields come straight from the inputs in the accept cycle so the first phase can be registered
   assign idx = acc ? req_addr[ADDR_W:2] : idx_q;
   assign wr  = acc ? req_wr : wr_q;
   assign bm  = acc ? req_bmask : bm_q;
   assign wd  = acc ? req_wdata : wd_q;
`ifdef SRAM_WR_SKIP_EN
   assign skip_lo = wr && bm[1:0] == 2'b00;
   assign skip_hi = wr && bm[3:2] == 2'b00;
`else
   assign skip_lo = 1'b0;
   assign skip_hi = 1'b0;
`endif
   assign last = cnt_q == CW'(WAIT_CYC - 1);
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req_vld ? (skip_lo ? (skip_hi ? DONE : HI) : LO) : IDLE;
         LO:      state_d = last ? (skip_hi ? DONE : HI) : LO;
         HI:      state_d = last ? DONE : HI;
         default: state_d = IDLE;
      endcase
      ph_hi   = state_d == HI;
      ph      = state_d == LO || ph_hi;
      cnt_d   = (state_d == state_q && (state_q == LO || state_q == HI)) ? cnt_q + 1'b1 : '0;
      addr_d  = ph ? {idx, ph_hi} : addr_q;
      dq_d    = (ph && wr) ? (ph_hi ? wd[31:16] : wd[15:0]) : dq_q;
      ce_d    = !ph;
      oe_d    = !(ph && !wr);
      we_d    = !(ph && wr);
      dqoe_d  = ph && wr;
      lb_d    = !(ph && (!wr || (ph_hi ? bm[2] : bm[0])));
      ub_d    = !(ph && (!wr || (ph_hi ? bm[3] : bm[1])));
      // read data is sampled on the last cycle of each phase; both halves land together on entry to DONE
      lo_d    = (state_q == LO && last) ? sram_dq_i : lo_q;
      rdata_d = (state_q == HI && last && !wr_q) ? {sram_dq_i, lo_q} : rdata_q;
      vld_d   = state_d == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         bm_q    <= '0;
         wd_q    <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         dq_q    <= '0;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         we_q    <= 1'b1;
         lb_q    <= 1'b1;
         ub_q    <= 1'b1;
         dqoe_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx;
         wr_q    <= wr;
         bm_q    <= bm;
         wd_q    <= wd;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         dq_q    <= dq_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         lb_q    <= lb_d;
         ub_q    <= ub_d;
         dqoe_q  <= dqoe_d;
         vld_q   <= vld_d;
      end
   end
   assign req_rdy    = state_q == IDLE;
   assign rsp_vld    = vld_q;
   assign rsp_rdata  = rdata_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_q;
   assign sram_dq_oe = dqoe_q;
   assign sram_ce_n  = ce_q;
   assign sram_oe_n  = oe_q;
   assign sram_we_n  = we_q;
   assign sram_lb_n  = lb_q;
   assign sram_ub_n  = ub_q;
endmodule

// File: tb/tb_sram_resp.sv
// tb_sram_resp: scoreboard bench for sram_resp with a behavioural SRAM (WAIT_CYC=1) plus a WAIT_CYC=3 instance.
module tb_sram_resp;
   localparam int AW = 18;
   logic clk = 1'b0, rst = 1'b1;
   logic req_vld = 1'b0, req_vld3 = 1'b0, req_wr = 1'b0;
   logic [AW:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0] req_bmask = '0;
   logic req_rdy, rsp_vld, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
   logic [31:0] rsp_rdata;
   logic [AW-1:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic req_rdy3, rsp_vld3, dq_oe3, ce_n3, oe_n3, we_n3, lb_n3, ub_n3;
   logic [31:0] rsp_rdata3;
   logic [AW-1:0] sram_addr3;
   logic [15:0] dq_o3;
   logic [5:0] strb;
   typedef struct {int cyc; logic [31:0] data;} exp_t;
   exp_t sbq[$];
   logic [15:0] mem [0:1023] = '{default: 16'h0};
   logic [31:0] shadow [0:511] = '{default: 32'h0};
   logic [31:0] last_ld = 32'h0;
   int cyc_cnt = 0;
   int checks = 0, errors = 0;
   sram_resp #(.ADDR_W(AW), .WAIT_CYC(1)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
      .req_wr(req_wr), .req_wdata(req_wdata), .req_bmask(req_bmask), .rsp_vld(rsp_vld),
      .rsp_rdata(rsp_rdata), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
      .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n));
   sram_resp #(.ADDR_W(AW), .WAIT_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .req_vld(req_vld3), .req_rdy(req_rdy3), .req_addr(req_addr),
      .req_wr(req_wr), .req_wdata(req_wdata), .req_bmask(req_bmask), .rsp_vld(rsp_vld3),
      .rsp_rdata(rsp_rdata3), .sram_addr(sram_addr3), .sram_dq_o(dq_o3), .sram_dq_i(16'h1234),
      .sram_dq_oe(dq_oe3), .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_we_n(we_n3),
      .sram_lb_n(lb_n3), .sram_ub_n(ub_n3));
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
   assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe};
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0;
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) mem[sram_addr[9:0]][7:0] <= sram_dq_o[7:0];
         if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq_o[15:8];
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (rsp_vld) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: rsp_vld at cycle %0d with nothing outstanding", cyc_cnt);
         end else begin
            e = sbq.pop_front();
            if (cyc_cnt !== e.cyc || rsp_rdata !== e.data) begin
               errors++;
               $display("FAIL rsp: got cycle %0d data %h, want cycle %0d data %h", cyc_cnt, rsp_rdata, e.cyc, e.data);
            end
         end
      end
   end
   task automatic do_req(input logic wr, input logic [AW:0] addr, input logic [31:0] wd, input logic [3:0] bm, output int n);
      exp_t e;
      int ph, i;
      req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_bmask = bm;
      n = cyc_cnt;
      ph = 2;
`ifdef SRAM_WR_SKIP_EN
      if (wr) ph = int'(|bm[1:0]) + int'(|bm[3:2]);
`endif
      i = int'(addr[10:2]);
      if (wr) begin
         for (int b = 0; b < 4; b++) if (bm[b]) shadow[i][8*b +: 8] = wd[8*b +: 8];
         e.data = last_ld;
      end else begin
         e.data = shadow[i];
         last_ld = e.data;
      end
      e.cyc = n + ph + 1;
      sbq.push_back(e);
      @(posedge clk); #1;
      req_vld = 1'b0; req_wr = 1'($urandom); req_addr = (AW+1)'($urandom);
      req_wdata = $urandom; req_bmask = 4'($urandom);
   endtask
   task automatic wait_idle;
      int k;
      k = 0;
      while (!(req_rdy && sbq.size() == 0) && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 40) begin
         errors++;
         $display("FAIL idle_timeout: req_rdy %b outstanding %0d after %0d cycles, want idle", req_rdy, sbq.size(), k);
      end
      @(posedge clk); #1;
   endtask
   task automatic test_reset;
      int pulses, bad;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({req_rdy, rsp_vld, rsp_rdata, sram_addr, sram_dq_o, strb} !== {1'b1, 1'b0, 32'h0, 18'h0, 16'h0, 6'b111110}) begin
         errors++;
         $display("FAIL reset_values: got %h, want %h", {req_rdy, rsp_vld, rsp_rdata, sram_addr, sram_dq_o, strb},
                  {1'b1, 1'b0, 32'h0, 18'h0, 16'h0, 6'b111110});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 19'h100;
      @(posedge clk); #1;
      req_vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (strb !== 6'b001000) begin
         errors++;
         $display("FAIL reset_pre_load: strobes %b, want %b", strb, 6'b001000);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({req_rdy, rsp_vld, strb} !== {1'b1, 1'b0, 6'b111110}) begin
         errors++;
         $display("FAIL reset_abort: rdy/vld/strobes %b, want %b", {req_rdy, rsp_vld, strb}, {1'b1, 1'b0, 6'b111110});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0; bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_vld) pulses++;
         if (strb !== 6'b111110 || !req_rdy) bad++;
      end
      checks++;
      if (pulses !== 0 || bad !== 0) begin
         errors++;
         $display("FAIL reset_quiet: %0d rsp pulses %0d busy/strobe cycles, want 0 and 0", pulses, bad);
      end
      @(posedge clk); #1;
   endtask
   task automatic test_word;
      int n;
      do_req(1'b1, 19'h100, 32'hDEADBEEF, 4'hF, n);
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h80, 16'hBEEF, 6'b010001}) begin
         errors++;
         $display("FAIL store_lo: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h80, 16'hBEEF, 6'b010001});
      end
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h81, 16'hDEAD, 6'b010001}) begin
         errors++;
         $display("FAIL store_hi: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h81, 16'hDEAD, 6'b010001});
      end
      wait_idle();
      do_req(1'b0, 19'h100, 32'h0, 4'h0, n);
      @(negedge clk);
      checks++;
      if ({sram_addr, strb} !== {18'h80, 6'b001000}) begin
         errors++;
         $display("FAIL load_lo: got %h, want %h", {sram_addr, strb}, {18'h80, 6'b001000});
      end
      @(negedge clk);
      checks++;
      if ({sram_addr, strb} !== {18'h81, 6'b001000}) begin
         errors++;
         $display("FAIL load_hi: got %h, want %h", {sram_addr, strb}, {18'h81, 6'b001000});
      end
      wait_idle();
   endtask
   task automatic test_byte;
      int n;
      do_req(1'b1, 19'h100, 32'h00AA0000, 4'b0100, n);
      @(negedge clk);
`ifdef SRAM_WR_SKIP_EN
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h81, 16'h00AA, 6'b010011}) begin
         errors++;
         $display("FAIL byte_hi_only: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h81, 16'h00AA, 6'b010011});
      end
      @(negedge clk);
      checks++;
      if (strb !== 6'b111110) begin
         errors++;
         $display("FAIL byte_done_strobes: got %b, want %b", strb, 6'b111110);
      end
`else
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h80, 16'h0000, 6'b010111}) begin
         errors++;
         $display("FAIL byte_lo_masked: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h80, 16'h0000, 6'b010111});
      end
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h81, 16'h00AA, 6'b010011}) begin
         errors++;
         $display("FAIL byte_hi: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h81, 16'h00AA, 6'b010011});
      end
`endif
      wait_idle();
      do_req(1'b0, 19'h100, 32'h0, 4'h0, n);
      wait_idle();
   endtask
   task automatic test_empty;
      int n;
      do_req(1'b1, 19'h104, 32'hFFFFFFFF, 4'b0000, n);
`ifdef SRAM_WR_SKIP_EN
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!sram_we_n || !sram_ce_n) bad++;
         end
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL empty_no_write: %0d strobed cycles, want 0", bad);
         end
      end
`else
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h82, 16'hFFFF, 6'b010111}) begin
         errors++;
         $display("FAIL empty_lo: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h82, 16'hFFFF, 6'b010111});
      end
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h83, 16'hFFFF, 6'b010111}) begin
         errors++;
         $display("FAIL empty_hi: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h83, 16'hFFFF, 6'b010111});
      end
`endif
      wait_idle();
      do_req(1'b0, 19'h104, 32'h0, 4'h0, n);
      wait_idle();
   endtask
   task automatic test_top_addr;
      int n;
      do_req(1'b1, 19'h7FFFF, 32'h12345678, 4'hF, n);
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o, strb} !== {18'h3FFFE, 16'h5678, 6'b010001}) begin
         errors++;
         $display("FAIL top_lo: got %h, want %h", {sram_addr, sram_dq_o, strb}, {18'h3FFFE, 16'h5678, 6'b010001});
      end
      @(negedge clk);
      checks++;
      if ({sram_addr, sram_dq_o} !== {18'h3FFFF, 16'h1234}) begin
         errors++;
         $display("FAIL top_hi: got %h, want %h", {sram_addr, sram_dq_o}, {18'h3FFFF, 16'h1234});
      end
      wait_idle();
      do_req(1'b0, 19'h7FFFC, 32'h0, 4'h0, n);
      wait_idle();
   endtask
   task automatic test_back_to_back;
      int acc[$];
      int q3[$];
      int e;
      req_wr = 1'b0; req_addr = 19'h200; req_bmask = 4'h0;
      req_vld3 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (req_vld3 && req_rdy3) begin
            acc.push_back(cyc_cnt);
            q3.push_back(cyc_cnt + 7);
         end
         if (rsp_vld3) begin
            checks++;
            if (q3.size() == 0) begin
               errors++;
               $display("FAIL b2b_rsp_unexpected: rsp_vld at cycle %0d", cyc_cnt);
            end else begin
               e = q3.pop_front();
               if (cyc_cnt !== e || rsp_rdata3 !== 32'h12341234) begin
                  errors++;
                  $display("FAIL b2b_rsp: got cycle %0d data %h, want cycle %0d data %h", cyc_cnt, rsp_rdata3, e, 32'h12341234);
               end
            end
         end
      end
      req_vld3 = 1'b0;
      checks++;
      if (acc.size() !== 2) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d accepts, want 2", acc.size());
      end else if (acc[1] - acc[0] !== 8) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d cycles, want 8", acc[1] - acc[0]);
      end
      checks++;
      if (q3.size() !== 0) begin
         errors++;
         $display("FAIL b2b_missing_rsp: %0d responses outstanding, want 0", q3.size());
      end
      @(posedge clk); #1;
   endtask
   initial begin
      test_reset();
      test_word();
      test_byte();
      test_empty();
      test_top_addr();
      test_back_to_back();
      checks++;
      if (sbq.size() !== 0) begin
         errors++;
         $display("FAIL sb_drain: %0d responses outstanding, want 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
